// File: rtl/vscale_hasti_sram_slave.sv
// HASTI word SRAM responder with wait states and two-cycle ERROR responses.
// Define VSCALE_HASTI_SRAM_ALIGN_CHECK_EN to turn misaligned accesses into errors.
module vscale_hasti_sram_slave #(
    parameter int unsigned NWORDS      = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);
    localparam int IW = $clog2(NWORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(NWORDS) << 2);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ERR1   = 2'd2;
    localparam logic [1:0] S_ERR2   = 2'd3;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic [2:0]    size;
    logic          wr;
    logic [31:0]   mem [NWORDS];

    logic [31:0] rel;
    logic        accept;
    logic        misalign;
    logic        bad;
    logic        data_done;
    logic [3:0]  lane_en;
    logic        unused;

    assign rel = haddr - BASE_ADDR;
    assign unused = ^{hburst, hmastlock, hprot, htrans[0], rel};

`ifdef VSCALE_HASTI_SRAM_ALIGN_CHECK_EN
    assign misalign = (hsize == 3'd1 && haddr[0]) ||
                      (hsize == 3'd2 && haddr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign bad = (haddr < BASE_ADDR) ||
                 ({1'b0, haddr} >= LIMIT) ||
                 (hsize > 3'd2) ||
                 misalign;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        unique case (state)
            S_ACCESS: hready = (wait_cnt == 4'd0);
            S_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            S_ERR2:   hresp = 1'b1;
            default: ;
        endcase
    end

    assign accept    = hready && htrans[1];
    assign data_done = (state == S_ACCESS) && (wait_cnt == 4'd0);
    assign hrdata    = (data_done && !wr) ? mem[idx] : 32'h0;

    // Misaligned offsets fall back to the naturally aligned lanes.
    always_comb begin
        lane_en = 4'b0000;
        unique case (1'b1)
            size == 3'd0: lane_en[off] = 1'b1;
            size == 3'd1: lane_en = off[1] ? 4'b1100 : 4'b0011;
            default:      lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (data_done && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            idx      <= '0;
            off      <= 2'd0;
            size     <= 3'd0;
            wr       <= 1'b0;
        end else if (hready) begin
            if (accept) begin
                state    <= bad ? S_ERR1 : S_ACCESS;
                wait_cnt <= bad ? 4'd0 : WS;
                idx      <= rel[IW+1:2];
                off      <= haddr[1:0];
                size     <= hsize;
                wr       <= hwrite;
            end else begin
                state <= S_IDLE;
            end
        end else begin
            if (state == S_ERR1) state <= S_ERR2;
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Randomised pipelined-master bench for vscale_hasti_sram_slave.
// Transaction-level memory model plus directed literal checks.
module tb_vscale_hasti_sram_slave;
    localparam int          NW   = 64;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          WS   = 2;
    localparam logic [31:0] TOP  = BASE + 32'(4 * NW);

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic        w;
        logic [2:0]  s;
        logic [31:0] d;
    } item_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] rd;
        logic        resp;
        int          lat;
    } done_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic        hmastlock = 1'b0;
    logic [3:0]  hprot = 4'd0;
    logic [1:0]  htrans = 2'd0;
    logic [31:0] hwdata = 32'h0;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    vscale_hasti_sram_slave #(
        .NWORDS(NW),
        .BASE_ADDR(BASE),
        .WAIT_STATES(WS)
    ) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .haddr(haddr),
        .hwrite(hwrite),
        .hsize(hsize),
        .hburst(hburst),
        .hmastlock(hmastlock),
        .hprot(hprot),
        .htrans(htrans),
        .hwdata(hwdata),
        .hrdata(hrdata),
        .hready(hready),
        .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    int errs = 0;
    int checks = 0;

    // model: current data phase (0 none, 1 okay, 2 error) and memory image
    int          m_kind = 0;
    int          m_wait = 0;
    int          m_errc = 0;
    logic        m_write = 1'b0;
    int          m_idx = 0;
    logic [1:0]  m_off = 2'd0;
    logic [2:0]  m_size = 3'd0;
    logic [31:0] m_mem [NW];
    logic        e_ready = 1'b1;

    // master side
    item_t       q[$];
    done_t       dq[$];
    logic        s_ready = 1'b1;
    logic        d_open = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    int          d_lat = 0;
    logic [31:0] cur_wd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [1:0] t, input logic [31:0] a,
                                 input logic w, input logic [2:0] s,
                                 input logic [31:0] d);
        item_t it;
        it.t = t; it.a = a; it.w = w; it.s = s; it.d = d;
        return it;
    endfunction

    function automatic item_t rnd_item();
        item_t it;
        int r;
        r = int'($urandom_range(0, 99));
        it.t = r < 10 ? 2'd0 : r < 15 ? 2'd1 : r < 60 ? 2'd2 : 2'd3;
        r = int'($urandom_range(0, 99));
        if (r < 80)      it.a = BASE + $urandom_range(0, 31);
        else if (r < 90) it.a = BASE + $urandom_range(0, 4 * NW - 1);
        else if (r < 95) it.a = TOP + $urandom_range(0, 15);
        else             it.a = BASE - 32'd1 - $urandom_range(0, 15);
        if ($urandom_range(0, 19) == 0) it.s = 3'($urandom_range(3, 7));
        else                            it.s = 3'($urandom_range(0, 2));
        it.w = 1'($urandom_range(0, 1));
        it.d = $urandom;
        return it;
    endfunction

    task automatic model_edge();
        bit err;
        if (e_ready) begin
            if (m_kind == 1 && m_write) begin
                for (int l = 0; l < 4; l++) begin
                    bit sel;
                    if (m_size == 3'd0)      sel = (l == int'(m_off));
                    else if (m_size == 3'd1) sel = ((l / 2) == int'(m_off[1]));
                    else                     sel = 1'b1;
                    if (sel) m_mem[m_idx][8*l +: 8] = hwdata[8*l +: 8];
                end
            end
            if (htrans[1]) begin
                err = (haddr < BASE) || (haddr >= TOP) || (hsize > 3'd2);
`ifdef VSCALE_HASTI_SRAM_ALIGN_CHECK_EN
                if (hsize == 3'd1 && haddr % 2 != 0) err = 1'b1;
                if (hsize == 3'd2 && haddr % 4 != 0) err = 1'b1;
`endif
                m_kind  = err ? 2 : 1;
                m_wait  = WS;
                m_errc  = 0;
                m_write = hwrite;
                m_off   = haddr[1:0];
                m_size  = hsize;
                m_idx   = err ? 0 : int'((haddr - BASE) / 4);
            end else begin
                m_kind = 0;
            end
        end else if (m_kind == 1) begin
            m_wait--;
        end else begin
            m_errc++;
        end
    endtask

    // one bus cycle: compare at negedge, advance model/master at posedge
    task automatic tick();
        logic        er, ep;
        logic [31:0] ed;
        item_t       nxt;
        @(negedge hclk);
        s_ready = hready;
        er = 1'b1; ep = 1'b0; ed = 32'h0;
        if (m_kind == 1) begin
            er = (m_wait == 0);
            if (er && !m_write) ed = m_mem[m_idx];
        end else if (m_kind == 2) begin
            er = (m_errc == 1);
            ep = 1'b1;
        end
        e_ready = er;
        chk("hready", {31'd0, hready}, {31'd0, er});
        chk("hresp", {31'd0, hresp}, {31'd0, ep});
        chk("hrdata", hrdata, ed);
        if (d_open) begin
            if (!hready) d_lat++;
            else dq.push_back('{d_write, d_addr, hrdata, hresp, d_lat});
        end
        @(posedge hclk);
        model_edge();
        nxt = mk(2'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        if (s_ready) begin
            d_open = htrans[1];
            if (d_open) begin
                d_write = hwrite;
                d_addr  = haddr;
                d_wdata = cur_wd;
                d_lat   = 0;
            end
            if (q.size() > 0) nxt = q.pop_front();
        end
        #1;
        if (s_ready) begin
            htrans = nxt.t;
            haddr  = nxt.a;
            hwrite = nxt.w;
            hsize  = nxt.s;
            cur_wd = nxt.d;
        end
        hwdata = (d_open && d_write) ? d_wdata : $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || d_open || htrans[1]) && n < 20000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20000) begin
            errs++;
            $display("FAIL drain: bus still busy after %0d cycles", n);
        end
    endtask

    task automatic chk_done(input string nm, input int i,
                            input logic [31:0] rd, input logic resp,
                            input int lat);
        checks++;
        if (i >= dq.size()) begin
            errs++;
            $display("FAIL %s: only %0d completions, wanted index %0d",
                     nm, dq.size(), i);
        end else begin
            chk({nm, ".resp"}, {31'd0, dq[i].resp}, {31'd0, resp});
            chk({nm, ".lat"}, 32'(dq[i].lat), 32'(lat));
            if (!dq[i].w && !resp) chk({nm, ".rdata"}, dq[i].rd, rd);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < NW; i++) m_mem[i] = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst.hready", {31'd0, hready}, 32'd1);
        chk("rst.hresp", {31'd0, hresp}, 32'd0);
        chk("rst.hrdata", hrdata, 32'h0);
        hresetn = 1'b1;

        for (int i = 0; i < NW; i++)
            q.push_back(mk(2'd2, BASE + 32'(4 * i), 1'b1, 3'd2, $urandom));
        drain();

        dq.delete();
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b0, 3'd2, 32'h0));
        drain();
        chk_done("b2b.wr", 0, 32'h0, 1'b0, WS);
        chk_done("b2b.rd", 1, 32'hDEADBEEF, 1'b0, WS);

        dq.delete();
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b1, 3'd2, 32'h11223344));
        q.push_back(mk(2'd3, BASE + 32'h13, 1'b1, 3'd0, 32'hAA5A5A5A));
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b0, 3'd2, 32'h0));
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b1, 3'd1, 32'h77775566));
        q.push_back(mk(2'd3, BASE + 32'h10, 1'b0, 3'd2, 32'h0));
        drain();
        chk_done("byte.rd", 2, 32'hAA223344, 1'b0, WS);
        chk_done("half.rd", 4, 32'hAA225566, 1'b0, WS);

        dq.delete();
        q.push_back(mk(2'd2, TOP, 1'b0, 3'd2, 32'h0));
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b0, 3'd3, 32'h0));
        q.push_back(mk(2'd2, TOP, 1'b1, 3'd2, 32'h0));
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b1, 3'd3, 32'h0));
        q.push_back(mk(2'd2, BASE - 32'd4, 1'b0, 3'd2, 32'h0));
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b0, 3'd2, 32'h0));
        drain();
        chk_done("err.top", 0, 32'h0, 1'b1, 1);
        chk_done("err.size", 1, 32'h0, 1'b1, 1);
        chk_done("err.wtop", 2, 32'h0, 1'b1, 1);
        chk_done("err.wsize", 3, 32'h0, 1'b1, 1);
        chk_done("err.low", 4, 32'h0, 1'b1, 1);
        chk_done("err.keep", 5, 32'hAA225566, 1'b0, WS);

        dq.delete();
        q.push_back(mk(2'd2, BASE + 32'h20, 1'b1, 3'd2, 32'hCAFEF00D));
        q.push_back(mk(2'd2, BASE + 32'h22, 1'b1, 3'd2, 32'h01020304));
        q.push_back(mk(2'd2, BASE + 32'h20, 1'b0, 3'd2, 32'h0));
        drain();
`ifdef VSCALE_HASTI_SRAM_ALIGN_CHECK_EN
        chk_done("mis.wr", 1, 32'h0, 1'b1, 1);
        chk_done("mis.rd", 2, 32'hCAFEF00D, 1'b0, WS);
`else
        chk_done("mis.wr", 1, 32'h0, 1'b0, WS);
        chk_done("mis.rd", 2, 32'h01020304, 1'b0, WS);
`endif

        q.push_back(mk(2'd2, BASE + 32'h10, 1'b1, 3'd2, 32'hFFFFFFFF));
        n = 0;
        while (!(d_open && d_lat >= 1) && n < 50) begin
            tick();
            n++;
        end
        chk("rst.reach", 32'(n < 50), 32'd1);
        hresetn = 1'b0;
        #1;
        chk("rstmid.hready", {31'd0, hready}, 32'd1);
        chk("rstmid.hresp", {31'd0, hresp}, 32'd0);
        m_kind = 0;
        d_open = 1'b0;
        q.delete();
        htrans = 2'd0;
        tick();
        tick();
        hresetn = 1'b1;
        dq.delete();
        q.push_back(mk(2'd2, BASE + 32'h10, 1'b0, 3'd2, 32'h0));
        drain();
        chk_done("rstmid.keep", 0, 32'hAA225566, 1'b0, WS);

        for (int i = 0; i < 1500; i++) q.push_back(rnd_item());
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vscale_hasti_sram_slave.md
Name: vscale_hasti_sram_slave

Overview:
HASTI (AHB-lite) responder for the vscale core's memory bus: a word-organised single-port SRAM with configurable wait states and ERROR responses.
- Sits on the far side of the core's HASTI master interface as the single slave on that bus. No hsel input.
- Supports byte, halfword and word accesses.
- Honours pipelined address and data phases, so a new address phase overlaps the completing data phase.
- Signals out-of-range and illegal-size accesses with the two-cycle AHB error response.

Parameters:
NWORDS, 1024, number of 32-bit words; power of two.
BASE_ADDR, 32'h0, byte address of word 0.
WAIT_STATES, 0, hready-low cycles inserted in every OKAY data phase (0..15).

Ports:
hclk  input  1  bus clock; all state on rising edge.
hresetn  input  1  asynchronous active-low reset.
haddr  input  32  byte address (address phase).
hwrite  input  1  1=write, 0=read (address phase).
hsize  input  3  0=byte, 1=half, 2=word; others illegal.
hburst  input  3  ignored (master always issues SINGLE).
hmastlock  input  1  ignored.
hprot  input  4  ignored.
htrans  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
hwdata  input  32  write data (data phase, one cycle after address).
hrdata  output  32  read data, valid when hready=1 in a read data phase.
hready  output  1  1=current data phase completes this cycle.
hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (hresetn low, async): state IDLE, hready=1, hresp=0, hrdata=0, wait counter=0, latched phase info cleared. Memory contents are not reset.
- Acceptance: address phase accepted on a rising edge where hready=1 and htrans is NONSEQ or SEQ. BUSY and IDLE are treated identically: no access, next state IDLE.
- Latched on acceptance: word index, byte offset haddr[1:0], hsize, hwrite, error flag.
- Error flag set when either:
  - haddr < BASE_ADDR, or haddr >= BASE_ADDR + 4*NWORDS;
  - hsize > 2.
- States:
  - IDLE: hready=1, hresp=0.
  - ACCESS: counter loaded with WAIT_STATES on acceptance; hready=(counter==0); counter decrements each cycle while nonzero.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Transitions:
  - Accepted legal access -> ACCESS.
  - Accepted erroneous access -> ERR1 -> ERR2.
  - Any state with hready=1 and no new transfer -> IDLE.
  - ACCESS/ERR2 with hready=1 and a new accepted transfer -> ACCESS or ERR1 directly (back-to-back, no bubble).
- Transfers presented during ERR1 are not accepted. The master drops them per AHB.
- Write commit: on the edge ending a write ACCESS phase (hready=1), hwdata is written under byte mask:
  - byte: lane haddr[1:0];
  - half: lanes {haddr[1],0} and {haddr[1],1};
  - word: all four lanes.
  - Unselected lanes are unchanged. hwdata is sampled only on that edge.
- Read data:
  - hrdata = mem[latched index], combinational, during a read ACCESS phase with hready=1. Full word is returned; the master extracts lanes.
  - hrdata=0 at all other times.
- Hazard: a read whose data phase immediately follows a write data phase to the same word returns the newly written value, because the commit happens before the read's data phase.
- Errors never modify memory.
- Reset asserted mid-phase drops any pending write, forces IDLE and hready=1 on assertion.

Optional Feature:
Macro VSCALE_HASTI_SRAM_ALIGN_CHECK_EN.
- Defined: a misaligned access (half with haddr[0]=1, word with haddr[1:0]!=0) sets the error flag, giving the two-cycle ERROR response with no write.
- Undefined: misaligned offsets are truncated. Half uses haddr[1]; word ignores haddr[1:0]. Response is OKAY.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF at 0x10, then read 0x10 back-to-back -> hready stays 1 throughout; read data phase hrdata=0xDEADBEEF.
- Byte write 0xAA at 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344. Half write 0x5566 at 0x10 -> 0xAA225566.
- WAIT_STATES=2: read 0x20 -> hready low exactly 2 cycles, then hready=1 with valid hrdata and hresp=0.
- Read at BASE_ADDR+4*NWORDS, or hsize=3 -> cycle1 hready=0/hresp=1, cycle2 hready=1/hresp=1. A following write to the same illegal range leaves memory unchanged.
- Word access at 0x22 with macro defined -> ERROR pair. Without macro -> OKAY, accesses word 0x20.
- WAIT_STATES=3: assert hresetn low during a write's wait cycles -> hready=1 and hresp=0 immediately; target word keeps its old value.
